// File: rtl/f_to_int.sv
// f_to_int: three-stage IEEE-754 binary32 to int32 converter with saturation counting.
// Define F_TO_INT_ROUND_EN for round-half-to-even; the default build truncates toward zero.
module f_to_int #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [15:0]       sat_count
);

  logic        s1_sign_r;
  logic [7:0]  s1_exp_r;
  logic [23:0] s1_sig_r;

  logic [7:0]  rsh_s;
  logic [7:0]  lsh_s;
  logic [31:0] mag_s;
  logic [31:0] mag_rnd_s;
  logic        carry_s;
  logic        ovf_s;
  logic        nan_s;
  logic        min_s;
  logic        sat_pos_s;
  logic        sat_neg_s;

  logic        s2_sign_r;
  logic [31:0] s2_mag_r;
  logic        s2_sat_pos_r;
  logic        s2_sat_neg_r;
  logic        s2_min_r;

  logic [31:0] res_s;
  logic        sat_s;
  logic [31:0] s3_res_r;
  logic        s3_sat_r;
  logic [2:0]  valid_r;
  logic [15:0] sat_count_r;

  // Stage 1: split operand; the hidden bit is clear for zero and subnormals.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_r <= 1'b0;
      s1_exp_r  <= 8'd0;
      s1_sig_r  <= 24'd0;
    end else begin
      s1_sign_r <= in0[31];
      s1_exp_r  <= in0[30:23];
      s1_sig_r  <= {(in0[30:23] != 8'd0), in0[22:0]};
    end
  end

  // Exponents 126..149 shift right by 150-E, 150..157 shift left by E-150.
  assign rsh_s = 8'd150 - s1_exp_r;
  assign lsh_s = s1_exp_r - 8'd150;

`ifdef F_TO_INT_ROUND_EN
  logic [55:0] rwide_s;
  logic        rnd_s;

  assign rwide_s = {8'd0, s1_sig_r, 24'd0} >> rsh_s;
`else
  logic [31:0] rtrunc_s;

  assign rtrunc_s = {8'd0, s1_sig_r} >> rsh_s;
`endif

  // Stage 2 datapath: align the significand and classify overflow and NaN.
  always_comb begin
    mag_s = 32'd0;
    ovf_s = 1'b0;
    nan_s = 1'b0;
    min_s = 1'b0;
`ifdef F_TO_INT_ROUND_EN
    rnd_s = 1'b0;
`endif
    if (s1_exp_r == 8'd255) begin
      nan_s = |s1_sig_r[22:0];
      ovf_s = ~(|s1_sig_r[22:0]);
    end else if (s1_exp_r >= 8'd158) begin
      if ((s1_exp_r == 8'd158) && s1_sign_r && (s1_sig_r[22:0] == 23'd0)) begin
        min_s = 1'b1;
      end else begin
        ovf_s = 1'b1;
      end
    end else if (s1_exp_r >= 8'd150) begin
      mag_s = {8'd0, s1_sig_r} << lsh_s;
    end else if (s1_exp_r >= 8'd126) begin
`ifdef F_TO_INT_ROUND_EN
      mag_s = rwide_s[55:24];
      rnd_s = rwide_s[23] & ((|rwide_s[22:0]) | rwide_s[24]);
`else
      mag_s = rtrunc_s;
`endif
    end else begin
      mag_s = 32'd0;
    end
  end

`ifdef F_TO_INT_ROUND_EN
  assign mag_rnd_s = mag_s + {31'd0, rnd_s};
  assign carry_s   = mag_rnd_s[31];
`else
  assign mag_rnd_s = mag_s;
  assign carry_s   = 1'b0;
`endif

  // NaN and a rounding carry saturate positive regardless of sign.
  assign sat_pos_s = nan_s | (ovf_s & ~s1_sign_r) | carry_s;
  assign sat_neg_s = ovf_s & s1_sign_r & ~carry_s;

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign_r    <= 1'b0;
      s2_mag_r     <= 32'd0;
      s2_sat_pos_r <= 1'b0;
      s2_sat_neg_r <= 1'b0;
      s2_min_r     <= 1'b0;
    end else begin
      s2_sign_r    <= s1_sign_r;
      s2_mag_r     <= mag_rnd_s;
      s2_sat_pos_r <= sat_pos_s;
      s2_sat_neg_r <= sat_neg_s;
      s2_min_r     <= min_s;
    end
  end

  // Stage 3 datapath: apply sign or substitute the saturation value.
  always_comb begin
    res_s = 32'd0;
    sat_s = 1'b0;
    if (s2_sat_pos_r) begin
      res_s = 32'h7FFF_FFFF;
      sat_s = 1'b1;
    end else if (s2_sat_neg_r) begin
      res_s = 32'h8000_0000;
      sat_s = 1'b1;
    end else if (s2_min_r) begin
      res_s = 32'h8000_0000;
    end else if (s2_sign_r) begin
      res_s = 32'd0 - s2_mag_r;
    end else begin
      res_s = s2_mag_r;
    end
  end

  // Stage 3 register and the running-qualified valid shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_res_r <= 32'd0;
      s3_sat_r <= 1'b0;
      valid_r  <= 3'd0;
    end else begin
      s3_res_r <= res_s;
      s3_sat_r <= sat_s;
      valid_r  <= {valid_r[1:0], running};
    end
  end

  // Saturation counter: cleared by run, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_r <= 16'd0;
    end else if (run) begin
      sat_count_r <= 16'd0;
    end else if (valid_r[2] && s3_sat_r && (sat_count_r != 16'hFFFF)) begin
      sat_count_r <= sat_count_r + 16'd1;
    end else begin
      sat_count_r <= sat_count_r;
    end
  end

  assign out0      = running ? s3_res_r : {DATA_W{1'b0}};
  assign sat_count = sat_count_r;

endmodule

// File: tb/tb_f_to_int.sv
// Randomized self-checking bench for f_to_int against a real-arithmetic reference model.
module tb_f_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        running = 1'b0;
  logic        run = 1'b0;
  logic [31:0] in0 = 32'd0;
  logic [31:0] out0;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  f_to_int #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run),
    .in0(in0), .out0(out0), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: value = sig * 2^(E-150), rounded or truncated, then clamped to int32.
  function automatic void model(input logic [31:0] x, output logic [31:0] r, output logic s);
    int  ex;
    real v, i, f, sv;
    r = 32'd0;
    s = 1'b0;
    if (x[30:23] == 8'd255) begin
      s = 1'b1;
      r = ((x[22:0] != 23'd0) || !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else if (x[30:23] != 8'd0) begin
      ex = int'(x[30:23]) - 150;
      v  = (8388608.0 + real'(x[22:0])) * (2.0 ** ex);
      i  = $floor(v);
`ifdef F_TO_INT_ROUND_EN
      f = v - i;
      if ((f > 0.5) || ((f == 0.5) && ($floor(i / 2.0) * 2.0 != i))) i = i + 1.0;
`else
      f = 0.0;
`endif
      sv = x[31] ? -i : i;
      if (sv > 2147483647.0) begin
        r = 32'h7FFF_FFFF; s = 1'b1;
      end else if (sv < -2147483648.0) begin
        r = 32'h8000_0000; s = 1'b1;
      end else begin
        r = 32'(longint'(sv));
      end
    end
  endfunction

  // Per-cycle history of inputs; a result is flushed if reset hit any of its three stages.
  logic [31:0] in_h  [8];
  logic        run_h [8];
  logic        rng_h [8];
  logic        rst_h [8];
  logic [15:0] mcnt = 16'd0;
  int          cyc = 0;

  initial begin
    for (int k = 0; k < 8; k++) begin
      in_h[k] = 32'd0; run_h[k] = 1'b0; rng_h[k] = 1'b0; rst_h[k] = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic        flushed, vld, s;
    logic [31:0] r;
    cyc = cyc + 1;
    in_h[cyc & 7] = in0; run_h[cyc & 7] = run; rng_h[cyc & 7] = running; rst_h[cyc & 7] = rst;
    flushed = rst_h[(cyc - 3) & 7] | rst_h[(cyc - 2) & 7] | rst_h[(cyc - 1) & 7];
    model(flushed ? 32'd0 : in_h[(cyc - 3) & 7], r, s);
    chk("out0", out0, running ? r : 32'd0);
    chk("sat_count", {16'd0, sat_count}, {16'd0, mcnt});
    vld = rng_h[(cyc - 3) & 7] & ~flushed;
    if (rst || run) mcnt = 16'd0;
    else if (vld && s && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic [31:0] x, input logic [31:0] e, input string nm);
    running = 1'b1;
    in0 = x;
    tick();
    in0 = 32'd0;
    tick();
    tick();
    chk(nm, out0, e);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [8];
    sp = '{32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000,
           32'h7F80_0000, 32'h8000_0000, 32'h3F00_0000, 32'hCEFF_FFFF};
    case ($urandom % 4)
      0: return $urandom;
      1: return {1'($urandom), 8'(120 + $urandom % 40), 23'($urandom)};
      2: return sp[$urandom % 8];
      default: return {1'($urandom), 8'(126 + $urandom % 4), 23'($urandom & 32'h0070_0000)};
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic        s;

    // Hand-computed pins of the reference model itself.
    model(32'h4049_0FDB, r, s); chk("model_pi", r, 32'd3);
    model(32'h3F00_0000, r, s); chk("model_half", r, 32'd0);
`ifdef F_TO_INT_ROUND_EN
    model(32'hC060_0000, r, s); chk("model_m3p5", r, 32'hFFFF_FFFC);
`else
    model(32'hC060_0000, r, s); chk("model_m3p5", r, 32'hFFFF_FFFD);
`endif
    model(32'hCF00_0000, r, s); chk("model_min", {r[31:1], s}, 32'h8000_0000);
    model(32'h4F00_0000, r, s); chk("model_ovf", {31'd0, s}, 32'd1);

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_out0", out0, 32'd0);
    chk("reset_sat", {16'd0, sat_count}, 32'd0);

    lit(32'h4049_0FDB, 32'd3, "pi");
    chk("pi_sat", {16'd0, sat_count}, 32'd0);
`ifdef F_TO_INT_ROUND_EN
    lit(32'hC060_0000, 32'hFFFF_FFFC, "m3p5");
    lit(32'h3FC0_0000, 32'd2, "one_p5");
`else
    lit(32'hC060_0000, 32'hFFFF_FFFD, "m3p5");
    lit(32'h3FC0_0000, 32'd1, "one_p5");
`endif
    lit(32'h3F00_0000, 32'd0, "half");
    lit(32'h4020_0000, 32'd2, "two_p5");
    lit(32'h8000_0000, 32'd0, "neg_zero");
    lit(32'h4F00_0000, 32'h7FFF_FFFF, "pos_ovf");

    // Back-to-back saturation corners.
    run = 1'b1; tick(); run = 1'b0;
    in0 = 32'h4F00_0000; tick();
    in0 = 32'hCF00_0000; tick();
    in0 = 32'h7FC0_0000; tick();
    in0 = 32'hFF80_0000; tick();
    in0 = 32'd0;
    repeat (4) tick();
    chk("b2b_sat", {16'd0, sat_count}, 32'd3);

    // Not running: no output, no counting; then run clears over a concurrent increment.
    running = 1'b0; in0 = 32'h4F00_0000;
    repeat (5) tick();
    chk("idle_out0", out0, 32'd0);
    chk("idle_sat", {16'd0, sat_count}, 32'd3);
    running = 1'b1;
    repeat (3) tick();
    run = 1'b1; tick(); run = 1'b0;
    chk("run_clear", {16'd0, sat_count}, 32'd0);
    repeat (4) tick();

    // Reset in the middle of a saturating stream.
    for (int i = 0; i < 20; i++) begin
      rst = (i == 2);
      in0 = 32'h4F00_0000;
      if (i == 3) begin
        running = 1'b1;
        chk("mid_rst_out0", out0, 32'd0);
        chk("mid_rst_sat", {16'd0, sat_count}, 32'd0);
      end
      tick();
    end
    rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom % 64 == 0);
      run     = ($urandom % 16 == 0);
      running = ($urandom % 4 != 0);
      in0     = pick();
      tick();
    end
    rst = 1'b0; run = 1'b0; running = 1'b1;

    // Drive the counter into its ceiling and past it.
    run = 1'b1; tick(); run = 1'b0;
    in0 = 32'h7F80_0000;
    repeat (65537) tick();
    in0 = 32'd0;
    repeat (5) tick();
    chk("sat_ceiling", {16'd0, sat_count}, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
